// File: rtl/uart_rx.sv
// 8N1 serial receiver matched to uart_tx timing (clk_bit clocks per bit).
// Define UART_RX_MAJORITY_EN to take every bit decision as a 2-of-3 vote.
module uart_rx #(
  parameter int clk_bit = 87
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       serial_ip,
  output logic       data_valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       active
);

  localparam logic [7:0] HALF_CNT = 8'((clk_bit - 1) / 2);
  localparam logic [7:0] FULL_CNT = 8'(clk_bit - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4,
    BREAK   = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] clk_count;
  logic [2:0] bit_count;
  logic [7:0] shift_reg;
  logic       stop_ok;
  logic       sync1;
  logic       rx_s;
  logic       bit_val;

  // Synchronizer flops reset high so reset release never mimics a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= serial_ip;
      rx_s  <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) hist <= 2'b11;
    else          hist <= {hist[0], rx_s};
  end

  assign bit_val = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      clk_count  <= 8'd0;
      bit_count  <= 3'd0;
      shift_reg  <= 8'd0;
      stop_ok    <= 1'b0;
      data       <= 8'd0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      active     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          clk_count <= 8'd0;
          bit_count <= 3'd0;
          if (!rx_s) begin
            state  <= START;
            active <= 1'b1;
          end
        end
        START: begin
          if (clk_count == HALF_CNT) begin
            clk_count <= 8'd0;
            if (!bit_val) begin
              state <= DATA;
            end else begin
              state  <= IDLE;
              active <= 1'b0;
            end
          end else begin
            clk_count <= clk_count + 8'd1;
          end
        end
        DATA: begin
          if (clk_count == FULL_CNT) begin
            clk_count            <= 8'd0;
            shift_reg[bit_count] <= bit_val;
            if (bit_count == 3'd7) begin
              bit_count <= 3'd0;
              state     <= STOP;
            end else begin
              bit_count <= bit_count + 3'd1;
            end
          end else begin
            clk_count <= clk_count + 8'd1;
          end
        end
        STOP: begin
          if (clk_count == FULL_CNT) begin
            clk_count <= 8'd0;
            stop_ok   <= bit_val;
            active    <= 1'b0;
            state     <= CLEANUP;
            if (bit_val) begin
              data       <= shift_reg;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_count <= clk_count + 8'd1;
          end
        end
        CLEANUP: begin
          // A low stop sample may be a break; wait for the line to recover.
          state <= stop_ok ? IDLE : BREAK;
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames, back-to-back, glitch, break, reset mid-frame.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CLK_BIT = 87;
  localparam int LAT     = (CLK_BIT - 1) / 2 + 9 * CLK_BIT + 4;
  localparam int GLT_OFS = (CLK_BIT - 1) / 2 + 1;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       serial_ip = 1'b1;
  logic       data_valid;
  logic [7:0] data;
  logic       frame_err;
  logic       active;

  uart_rx #(.clk_bit(CLK_BIT)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .serial_ip  (serial_ip),
    .data_valid (data_valid),
    .data       (data),
    .frame_err  (frame_err),
    .active     (active)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int   vectors = 0;
  int   miscompares = 0;
  int   valid_cyc[$];
  logic [7:0] valid_dat[$];
  int   ferr_cnt = 0;
  int   act_rise = 0;
  int   wide_cnt = 0;
  int   both_cnt = 0;
  logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_act = 1'b0;
  int   start_cyc;

  always @(negedge i_clk) begin
    if (data_valid) begin
      valid_cyc.push_back(cyc);
      valid_dat.push_back(data);
    end
    if (frame_err) ferr_cnt++;
    if (active && !prev_act) act_rise++;
    if ((data_valid && prev_valid) || (frame_err && prev_ferr)) wide_cnt++;
    if (data_valid && frame_err) both_cnt++;
    prev_valid = data_valid;
    prev_ferr  = frame_err;
    prev_act   = active;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  function automatic int within_one(input int obs, input int exp);
    return (obs >= exp - 1 && obs <= exp + 1) ? exp : obs;
  endfunction

  // Entry and exit are at posedge+1; each bit lasts exactly CLK_BIT cycles.
  task automatic drive_bit(input logic v, input bit glitch);
    serial_ip = v;
    if (glitch) begin
      repeat (GLT_OFS) @(posedge i_clk);
      #1 serial_ip = ~v;
      @(posedge i_clk);
      #1 serial_ip = v;
      repeat (CLK_BIT - GLT_OFS - 1) @(posedge i_clk);
    end else begin
      repeat (CLK_BIT) @(posedge i_clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch);
    start_cyc = cyc;
    drive_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) drive_bit(b[i], glitch);
    drive_bit(stop, glitch);
  endtask

  task automatic idle(input int n);
    serial_ip = 1'b1;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  function automatic int last_data();
    return (valid_dat.size() > 0) ? int'(valid_dat[valid_dat.size()-1]) : -1;
  endfunction

  function automatic int last_cyc();
    return (valid_cyc.size() > 0) ? valid_cyc[valid_cyc.size()-1] : -1;
  endfunction

  int nv, nf, na, fc;

  initial begin
    // 1: reset and idle
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    check_eq("rst_data", int'(data), 0);
    check_eq("rst_valid", int'(data_valid), 0);
    check_eq("rst_ferr", int'(frame_err), 0);
    check_eq("rst_active", int'(active), 0);
    idle(1000);
    check_eq("idle_valids", valid_cyc.size(), 0);
    check_eq("idle_ferrs", ferr_cnt, 0);

    // 2: single frame 0xA5
    na = act_rise;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    check_eq("a5_count", valid_cyc.size(), 1);
    check_eq("a5_data", last_data(), 8'hA5);
    check_eq("a5_latency", within_one(last_cyc() - start_cyc, LAT), LAT);
    check_eq("a5_active_rose", act_rise - na, 1);
    check_eq("a5_active_end", int'(active), 0);
    check_eq("a5_ferr", ferr_cnt, 0);

    // 3: back-to-back 0x00, 0xFF
    nv = valid_cyc.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(20);
    check_eq("b2b_count", valid_cyc.size() - nv, 2);
    if (valid_cyc.size() >= nv + 2) begin
      check_eq("b2b_first", int'(valid_dat[nv]), 8'h00);
      check_eq("b2b_second", int'(valid_dat[nv+1]), 8'hFF);
      check_eq("b2b_gap", within_one(valid_cyc[nv+1] - valid_cyc[nv], 10 * CLK_BIT),
               10 * CLK_BIT);
    end

    // 4: 20-cycle glitch rejected, then 0x3C
    nv = valid_cyc.size(); nf = ferr_cnt; na = act_rise;
    serial_ip = 1'b0;
    repeat (20) @(posedge i_clk);
    #1 idle(200);
    check_eq("glitch_active_rose", act_rise - na, 1);
    check_eq("glitch_active_end", int'(active), 0);
    check_eq("glitch_valids", valid_cyc.size() - nv, 0);
    check_eq("glitch_ferrs", ferr_cnt - nf, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    check_eq("3c_data", last_data(), 8'h3C);
    check_eq("3c_count", valid_cyc.size() - nv, 1);

    // 5: framing error 0x55 with break, then 0x81
    nv = valid_cyc.size(); nf = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    na = act_rise;
    serial_ip = 1'b0;
    repeat (300) @(posedge i_clk);
    #1;
    check_eq("brk_ferr", ferr_cnt - nf, 1);
    check_eq("brk_valids", valid_cyc.size() - nv, 0);
    check_eq("brk_data_held", int'(data), 8'h3C);
    check_eq("brk_no_activity", act_rise - na, 0);
    check_eq("brk_active", int'(active), 0);
    idle(50);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    check_eq("81_data", last_data(), 8'h81);
    check_eq("81_count", valid_cyc.size() - nv, 1);

    // 6: reset during bit 4 of 0xF0 (bits 4..7 high, so no false restart)
    nv = valid_cyc.size(); nf = ferr_cnt;
    start_cyc = cyc;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
    serial_ip = 1'b1;
    repeat (CLK_BIT / 2) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check_eq("mrst_active", int'(active), 0);
    check_eq("mrst_data", int'(data), 0);
    check_eq("mrst_valid", int'(data_valid), 0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    idle(6 * CLK_BIT);
    check_eq("mrst_no_valid", valid_cyc.size() - nv, 0);
    check_eq("mrst_no_ferr", ferr_cnt - nf, 0);
    check_eq("mrst_idle_active", int'(active), 0);

`ifdef UART_RX_MAJORITY_EN
    nv = valid_cyc.size();
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(20);
    check_eq("maj_c3_data", last_data(), 8'hC3);
    check_eq("maj_c3_count", valid_cyc.size() - nv, 1);
`endif

    fc = ferr_cnt;
    check_eq("strobe_width", wide_cnt, 0);
    check_eq("strobe_overlap", both_cnt, 0);
    check_eq("total_ferrs", fc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
